// File: rtl/l80_uart_fifo_io_pkg.sv
// Shared register map, STAT/CTRL bit positions and TX drain FSM encodings for the
// light8080 UART FIFO adapter; the SOC address decoder imports the same package.
package l80_uart_fifo_io_pkg;

  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_CTRL  = 2'd1;
  localparam logic [1:0] REG_RXCNT = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd3;

  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_ACTIVE = 1;
  localparam int STAT_RX_NEMPTY = 4;
  localparam int STAT_RX_FULL   = 5;
  localparam int STAT_RX_OVF    = 6;
  localparam int STAT_TX_OVF    = 7;

  localparam int CTRL_RX_IE  = 0;
  localparam int CTRL_TXE_IE = 1;
  localparam int CTRL_FLUSH  = 7;

  localparam logic [1:0] TX_IDLE    = 2'd0;
  localparam logic [1:0] TX_LOAD    = 2'd1;
  localparam logic [1:0] TX_WAIT_HI = 2'd2;
  localparam logic [1:0] TX_WAIT_LO = 2'd3;

  // Bit 4 = data available and bit 0 = cannot accept a write, so legacy polling loops keep working.
  typedef struct packed {
    logic       tx_ovf;
    logic       rx_ovf;
    logic       rx_full;
    logic       rx_nempty;
    logic [1:0] rsvd;
    logic       tx_active;
    logic       tx_full;
  } stat_t;

  function automatic logic [7:0] sat8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/l80_uart_fifo_io_sync_fifo.sv
// Synchronous show-ahead FIFO with flush; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is dropped and drop_o flags it.
module l80_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      din_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  drop_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   cnt_q;
  logic                  do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      cnt_q <= cnt_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/l80_uart_fifo_io.sv
// IO-space UART adapter for light8080: RX/TX FIFOs, sticky overflow flags, CTRL register.
// Optional level interrupt output is built only when L80_UART_IRQ_EN is defined.
module l80_uart_fifo_io
  import l80_uart_fifo_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR     = 8'h80,
  parameter int         RX_DEPTH_LOG2 = 4,
  parameter int         TX_DEPTH_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_io,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] io_dout,
  output logic [7:0] uart_tx_byte,
  output logic       uart_transmit,
  input  logic       uart_busy,
  input  logic [7:0] uart_rx_byte,
  input  logic       uart_received
`ifdef L80_UART_IRQ_EN
  ,
  output logic       irq
`endif
);

  logic [7:0] off;
  logic [3:0] sel;
  assign off = cpu_addr - BASE_ADDR;

  always_comb begin
    sel = '0;
    if (cpu_io && off < 8'd4) sel[off[1:0]] = 1'b1;
  end

  // Edge detect per access so a strobe held for many cycles acts once.
  logic rd_data_lvl, rd_stat_lvl, wr_data_lvl, wr_ctrl_lvl;
  logic rd_data_q, rd_stat_q, wr_data_q, wr_ctrl_q;
  logic rd_data_p, rd_stat_p, wr_data_p, wr_ctrl_p;

  assign rd_data_lvl = cpu_rd & sel[REG_DATA];
  assign rd_stat_lvl = cpu_rd & sel[REG_STAT];
  assign wr_data_lvl = cpu_wr & sel[REG_DATA];
  assign wr_ctrl_lvl = cpu_wr & sel[REG_CTRL];
  assign rd_data_p   = rd_data_lvl & ~rd_data_q;
  assign rd_stat_p   = rd_stat_lvl & ~rd_stat_q;
  assign wr_data_p   = wr_data_lvl & ~wr_data_q;
  assign wr_ctrl_p   = wr_ctrl_lvl & ~wr_ctrl_q;

  logic [6:0] ctrl_q;
  logic       flush;
  assign flush = wr_ctrl_p & cpu_dout[CTRL_FLUSH];

  logic [7:0]             rx_head, tx_head;
  logic [RX_DEPTH_LOG2:0] rx_cnt;
  logic [TX_DEPTH_LOG2:0] tx_cnt;
  logic rx_full, rx_empty, rx_drop, tx_full, tx_empty, tx_drop;
  logic [1:0] state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic       tx_pop;

  assign tx_pop = (state_q == TX_LOAD);

  l80_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clock(clock), .reset(reset), .flush_i(flush),
    .push_i(uart_received), .pop_i(rd_data_p), .din_i(uart_rx_byte),
    .head_o(rx_head), .count_o(rx_cnt), .full_o(rx_full), .empty_o(rx_empty),
    .drop_o(rx_drop)
  );

  l80_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clock(clock), .reset(reset), .flush_i(flush),
    .push_i(wr_data_p), .pop_i(tx_pop), .din_i(cpu_dout),
    .head_o(tx_head), .count_o(tx_cnt), .full_o(tx_full), .empty_o(tx_empty),
    .drop_o(tx_drop)
  );

  logic rx_ovf_q, tx_ovf_q, tx_active;
  assign tx_active = ~tx_empty | (state_q != TX_IDLE) | uart_busy;

  stat_t stat;
  assign stat = '{tx_ovf: tx_ovf_q, rx_ovf: rx_ovf_q, rx_full: rx_full,
                  rx_nempty: ~rx_empty, rsvd: 2'b00, tx_active: tx_active,
                  tx_full: tx_full};

  logic [7:0] io_dout_q, io_dout_d;
  always_comb begin
    io_dout_d = io_dout_q;
    if (sel[REG_DATA])       io_dout_d = rx_empty ? 8'h00 : rx_head;
    else if (sel[REG_CTRL])  io_dout_d = {1'b0, ctrl_q};
    else if (sel[REG_RXCNT]) io_dout_d = sat8(16'(rx_cnt));
    else if (sel[REG_STAT])  io_dout_d = stat;
  end

  // WAIT_HI gives up after 4 cycles so a uart that never asserts busy cannot stall the drain.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      TX_IDLE:    if (!tx_empty) state_d = TX_LOAD;
      TX_LOAD: begin
        state_d = TX_WAIT_HI;
        wcnt_d  = '0;
      end
      TX_WAIT_HI: begin
        if (uart_busy)            state_d = TX_WAIT_LO;
        else if (wcnt_q == 2'd3)  state_d = TX_IDLE;
        else                      wcnt_d  = wcnt_q + 2'd1;
      end
      default:    if (!uart_busy) state_d = TX_IDLE;
    endcase
  end

  logic [7:0] tx_byte_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q <= 1'b0;
      rd_stat_q <= 1'b0;
      wr_data_q <= 1'b0;
      wr_ctrl_q <= 1'b0;
      ctrl_q    <= '0;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      io_dout_q <= 8'h00;
      state_q   <= TX_IDLE;
      wcnt_q    <= '0;
      tx_byte_q <= 8'h00;
    end else begin
      rd_data_q <= rd_data_lvl;
      rd_stat_q <= rd_stat_lvl;
      wr_data_q <= wr_data_lvl;
      wr_ctrl_q <= wr_ctrl_lvl;
      if (wr_ctrl_p) ctrl_q <= cpu_dout[6:0];
      rx_ovf_q  <= rx_drop | (rx_ovf_q & ~rd_stat_p);
      tx_ovf_q  <= tx_drop | (tx_ovf_q & ~rd_stat_p);
      io_dout_q <= io_dout_d;
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      // Capture on entry to LOAD so the byte is stable while the start pulse is high.
      if (state_q == TX_IDLE && !tx_empty) tx_byte_q <= tx_head;
    end
  end

  assign io_dout       = io_dout_q;
  assign uart_tx_byte  = tx_byte_q;
  assign uart_transmit = (state_q == TX_LOAD);

`ifdef L80_UART_IRQ_EN
  logic irq_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else        irq_q <= (ctrl_q[CTRL_RX_IE] & ~rx_empty) |
                         (ctrl_q[CTRL_TXE_IE] & ~tx_active) | rx_ovf_q;
  end
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_l80_uart_fifo_io.sv
// Scoreboard bench for l80_uart_fifo_io (RX/TX depth 4); irq checks only with L80_UART_IRQ_EN.
module tb_l80_uart_fifo_io;

  localparam logic [7:0] BASE = 8'h80;
  localparam logic [1:0] R_DATA = 2'd0, R_CTRL = 2'd1, R_RXCNT = 2'd2, R_STAT = 2'd3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cpu_addr = 8'h00;
  logic       cpu_io = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0] cpu_dout = 8'h00;
  logic [7:0] io_dout, uart_tx_byte;
  logic       uart_transmit;
  logic       uart_busy = 1'b0;
  logic [7:0] uart_rx_byte = 8'h00;
  logic       uart_received = 1'b0;
`ifdef L80_UART_IRQ_EN
  logic       irq;
`endif

  always #5 clock = ~clock;

  l80_uart_fifo_io #(.BASE_ADDR(BASE), .RX_DEPTH_LOG2(2), .TX_DEPTH_LOG2(2)) dut (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_io(cpu_io),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .io_dout(io_dout),
    .uart_tx_byte(uart_tx_byte), .uart_transmit(uart_transmit), .uart_busy(uart_busy),
    .uart_rx_byte(uart_rx_byte), .uart_received(uart_received)
`ifdef L80_UART_IRQ_EN
    , .irq(irq)
`endif
  );

  int n_chk = 0, n_fail = 0;
  int tx_pulses = 0;
  int busy_cnt = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Uart core model: each start pulse is scored, then busy is held for 20 cycles.
  always @(negedge clock) begin
    if (uart_transmit) begin
      tx_pulses++;
      chk("tx_while_busy", uart_busy, 1'b0);
      if (tx_exp.size() == 0) chk("tx_extra", 1, 0);
      else chk("tx_byte", uart_tx_byte, tx_exp.pop_front());
      busy_cnt = 20;
      uart_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) uart_busy = 1'b0;
    end
  end

  task automatic io_rd(input logic [1:0] r, input int hold, output logic [7:0] d);
    @(negedge clock);
    cpu_io = 1'b1; cpu_addr = BASE + 8'(r); cpu_rd = 1'b1;
    @(posedge clock); #1;
    d = io_dout;
    repeat (hold - 1) @(posedge clock);
    #1;
    cpu_rd = 1'b0; cpu_io = 1'b0;
    @(posedge clock);
  endtask

  task automatic io_wr(input logic [1:0] r, input logic [7:0] v, input int hold);
    @(negedge clock);
    cpu_io = 1'b1; cpu_addr = BASE + 8'(r); cpu_wr = 1'b1; cpu_dout = v;
    repeat (hold) @(posedge clock);
    #1;
    cpu_wr = 1'b0; cpu_io = 1'b0;
    @(posedge clock);
  endtask

  task automatic rd_data(input string tag);
    logic [7:0] d, e;
    e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'h00;
    io_rd(R_DATA, 1, d);
    chk(tag, d, e);
  endtask

  task automatic rx_push(input logic [7:0] b, input bit kept);
    @(negedge clock);
    uart_rx_byte = b; uart_received = 1'b1;
    if (kept) rx_exp.push_back(b);
    @(negedge clock);
    uart_received = 1'b0;
  endtask

  task automatic tx_wr(input logic [7:0] b);
    tx_exp.push_back(b);
    io_wr(R_DATA, b, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((tx_exp.size() != 0 || uart_busy) && n < 2000) begin
      @(posedge clock); n++;
    end
    chk(tag, n < 2000, 1'b1);
    repeat (3) @(posedge clock);
  endtask

  initial begin
    logic [7:0] d, e;
    int p0, n;

    // Reset state
    #1;
    chk("rst_io_dout", io_dout, 8'h00);
    chk("rst_tx_byte", uart_tx_byte, 8'h00);
    chk("rst_transmit", uart_transmit, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    io_rd(R_STAT, 1, d);  chk("rst_stat", d, 8'h00);
    io_rd(R_RXCNT, 1, d); chk("rst_rxcnt", d, 8'h00);

    // 1: RX burst
    rx_push(8'h41, 1); rx_push(8'h42, 1); rx_push(8'h43, 1);
    io_rd(R_RXCNT, 1, d); chk("t1_rxcnt", d, 8'd3);
    io_rd(R_STAT, 1, d);  chk("t1_stat4", d[4], 1'b1);
    rd_data("t1_data0"); rd_data("t1_data1"); rd_data("t1_data2");
    io_rd(R_STAT, 1, d);  chk("t1_stat4_empty", d[4], 1'b0);
    rd_data("t1_data_empty");

    // 2: RX overflow on a depth-4 FIFO
    for (int i = 0; i < 5; i++) rx_push(8'h60 + 8'(i), i < 4);
    io_rd(R_RXCNT, 1, d); chk("t2_rxcnt", d, 8'd4);
    io_rd(R_STAT, 1, d);  chk("t2_ovf_set", d[6], 1'b1);
    chk("t2_full", d[5], 1'b1);
    io_rd(R_STAT, 1, d);  chk("t2_ovf_clr", d[6], 1'b0);
    for (int i = 0; i < 4; i++) rd_data("t2_drain");

    // 3: TX stream
    p0 = tx_pulses;
    for (int i = 0; i < 4; i++) tx_wr(8'h10 + 8'(i));
    io_rd(R_STAT, 1, d);  chk("t3_active", d[1], 1'b1);
    wait_idle("t3_timeout");
    chk("t3_pulses", tx_pulses - p0, 4);
    io_rd(R_STAT, 1, d);  chk("t3_stat_idle", d, 8'h00);

    // 4: held strobes
    rx_push(8'hA1, 1); rx_push(8'hA2, 1); rx_push(8'hA3, 1);
    e = rx_exp.pop_front();
    io_rd(R_DATA, 3, d);  chk("t4_held_rd_data", d, e);
    io_rd(R_RXCNT, 1, d); chk("t4_held_rd_cnt", d, 8'd2);
    rd_data("t4_next0"); rd_data("t4_next1");
    p0 = tx_pulses;
    tx_exp.push_back(8'h55);
    io_wr(R_DATA, 8'h55, 3);
    wait_idle("t4_timeout");
    chk("t4_held_wr_pulses", tx_pulses - p0, 1);

    // 5: push and pop together while full
    for (int i = 0; i < 4; i++) rx_push(8'hB0 + 8'(i), 1);
    e = rx_exp.pop_front();
    @(negedge clock);
    uart_rx_byte = 8'hB4; uart_received = 1'b1;
    cpu_io = 1'b1; cpu_addr = BASE; cpu_rd = 1'b1;
    rx_exp.push_back(8'hB4);
    @(posedge clock); #1;
    d = io_dout;
    uart_received = 1'b0; cpu_rd = 1'b0; cpu_io = 1'b0;
    @(posedge clock);
    chk("t5_pop_data", d, e);
    io_rd(R_RXCNT, 1, d); chk("t5_rxcnt", d, 8'd4);
    io_rd(R_STAT, 1, d);  chk("t5_no_ovf", d[6], 1'b0);
    for (int i = 0; i < 4; i++) rd_data("t5_drain");

    // 6a: flush with both FIFOs holding data; only the byte already loaded goes out
    rx_push(8'hC1, 0); rx_push(8'hC2, 0);
    p0 = tx_pulses;
    tx_exp.push_back(8'hD0);
    io_wr(R_DATA, 8'hD0, 1);
    io_wr(R_DATA, 8'hD1, 1);
    io_wr(R_DATA, 8'hD2, 1);
    io_wr(R_CTRL, 8'h80, 1);
    io_rd(R_RXCNT, 1, d); chk("t6_flush_rxcnt", d, 8'h00);
    wait_idle("t6_flush_timeout");
    chk("t6_flush_pulses", tx_pulses - p0, 1);
    io_rd(R_STAT, 1, d);  chk("t6_flush_stat", d, 8'h00);
    io_rd(R_CTRL, 1, d);  chk("t6_ctrl_bit7_wo", d, 8'h00);

    // 6b: reset during WAIT_LO
    io_wr(R_CTRL, 8'h03, 1);
    io_rd(R_CTRL, 1, d);  chk("t6_ctrl_rb", d, 8'h03);
    tx_wr(8'h77);
    n = 0;
    while (!uart_busy && n < 50) begin @(posedge clock); n++; end
    chk("t6_busy_timeout", n < 50, 1'b1);
    repeat (2) @(posedge clock);
    io_rd(R_STAT, 1, d);  chk("t6_pre_rst_active", d[1], 1'b1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t6_rst_io_dout", io_dout, 8'h00);
    chk("t6_rst_tx_byte", uart_tx_byte, 8'h00);
    chk("t6_rst_transmit", uart_transmit, 1'b0);
`ifdef L80_UART_IRQ_EN
    chk("t6_rst_irq", irq, 1'b0);
`endif
    @(negedge clock);
    reset = 1'b0;
    wait_idle("t6_rst_timeout");
    io_rd(R_CTRL, 1, d);  chk("t6_rst_ctrl", d, 8'h00);
    io_rd(R_RXCNT, 1, d); chk("t6_rst_rxcnt", d, 8'h00);

`ifdef L80_UART_IRQ_EN
    // 6c: irq from rx_ie, registered one cycle after the push
    io_wr(R_CTRL, 8'h01, 1);
    @(negedge clock);
    uart_rx_byte = 8'hE5; uart_received = 1'b1;
    rx_exp.push_back(8'hE5);
    @(posedge clock); #1;
    chk("t6_irq_early", irq, 1'b0);
    uart_received = 1'b0;
    @(posedge clock); #1;
    chk("t6_irq_set", irq, 1'b1);
    rd_data("t6_irq_data");
    @(posedge clock); #1;
    chk("t6_irq_clr", irq, 1'b0);
`endif

    chk("end_rx_sb_empty", rx_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
